// File: rtl/trace_capture.sv
// trace_capture: observational sink for core commit/debug trace.
// Each cycle it samples up to two events (one memory access, one register
// write), packs them into {type, idx, data} records, and buffers them in a
// small FIFO drained over a valid/ready stream. The core is never stalled.
// Records that do not fit are discarded and counted in drop_cnt.
//
// Stream handshake: m_valid is high whenever the FIFO holds a record, and
// m_data then shows the head record. A record is consumed on a rising edge
// where m_valid & m_ready. m_valid never depends on m_ready, and m_data holds
// steady while m_valid=1 and m_ready=0.
module trace_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture_en,
  input  logic                       reg_write_sig,
  input  logic [4:0]                 reg_num,
  input  logic [DATA_W-1:0]          reg_data,
  input  logic                       wr,
  input  logic                       rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [DATA_W-1:0]          rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [2+ADDR_W+DATA_W-1:0] m_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_cnt,
  output logic                       err_wr_rd
);

  localparam int REC_W = 2 + ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_p1;

  logic             mem_ev, reg_ev, pop;
  logic [REC_W-1:0] rec_mem, rec_reg, rec_a, rec_b;
  logic [1:0]       n_ev, n_push, n_drop;
  logic [LVL_W-1:0] free;
  logic [16:0]      drop_sum;
  logic [15:0]      drop_next;

  // Event detection, record packing and space check against the occupancy
  // at the start of the cycle (a same-cycle pop does not make room).
  always_comb begin
    mem_ev    = capture_en & (wr | rd);
    reg_ev    = capture_en & reg_write_sig & (reg_num != 5'd0);
    rec_mem   = wr ? {2'b10, addr, wr_data} : {2'b11, addr, rd_data};
    rec_reg   = {2'b01, ADDR_W'(reg_num), reg_data};
    rec_a     = mem_ev ? rec_mem : rec_reg;
    rec_b     = rec_reg;
    n_ev      = {1'b0, mem_ev} + {1'b0, reg_ev};
    free      = DEPTH_L - level;
    n_push    = n_ev;
    if (free < LVL_W'(n_ev)) n_push = free[1:0];
    n_drop    = n_ev - n_push;
    drop_sum  = {1'b0, drop_cnt} + 17'(n_drop);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    wr_ptr_p1 = wr_ptr + PTR_W'(1);
    pop       = m_valid & m_ready;
  end

  // Head of FIFO drives the stream; zero when empty.
  always_comb begin
    m_valid = (level != '0);
    m_data  = m_valid ? mem[rd_ptr] : '0;
  end

  // Record storage; contents are only meaningful between rd_ptr and wr_ptr,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    if (n_push != 2'd0) mem[wr_ptr]    <= rec_a;
    if (n_push == 2'd2) mem[wr_ptr_p1] <= rec_b;
  end

  // Pointers, occupancy, drop counter and sticky wr/rd conflict flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      drop_cnt  <= '0;
      err_wr_rd <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PTR_W'(n_push);
      rd_ptr   <= rd_ptr + PTR_W'(pop);
      level    <= level + LVL_W'(n_push) - LVL_W'(pop);
      drop_cnt <= drop_next;
      if (capture_en & wr & rd) err_wr_rd <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: one linear sequence of steps with
// hand-computed expected records, occupancy, drop counts and error flag.
module tb_trace_capture;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 16;
  localparam int REC_W  = 2 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              capture_en, reg_write_sig, wr, rd, m_ready;
  logic [4:0]        reg_num;
  logic [DATA_W-1:0] reg_data, wr_data, rd_data;
  logic [ADDR_W-1:0] addr;
  logic              m_valid;
  logic [REC_W-1:0]  m_data;
  logic [4:0]        level;
  logic [15:0]       drop_cnt;
  logic              err_wr_rd;

  int checks = 0;
  int errors = 0;

  trace_capture #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .capture_en(capture_en),
    .reg_write_sig(reg_write_sig), .reg_num(reg_num), .reg_data(reg_data),
    .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level), .drop_cnt(drop_cnt), .err_wr_rd(err_wr_rd)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [REC_W-1:0] rec(input logic [1:0] t,
                                           input logic [ADDR_W-1:0] idx,
                                           input logic [DATA_W-1:0] d);
    return {t, idx, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    reg_write_sig = 1'b0;
    wr            = 1'b0;
    rd            = 1'b0;
  endtask

  task automatic set_reg(input logic [4:0] n, input logic [31:0] d);
    reg_write_sig = 1'b1;
    reg_num       = n;
    reg_data      = d;
  endtask

  initial begin
    reset = 1'b0; capture_en = 1'b1; m_ready = 1'b0;
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_data",  64'(m_data), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    chk("rst_err",   64'(err_wr_rd), 64'd0);
    reset = 1'b1;
    tick();

    // Single reg write, next-cycle visibility
    set_reg(5'd5, 32'hDEADBEEF);
    tick(); clr();
    chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_data",  64'(m_data), 64'(rec(2'b01, 9'h005, 32'hDEADBEEF)));
    chk("t1_level", 64'(level), 64'd1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("t1_pop_level", 64'(level), 64'd0);
    chk("t1_pop_valid", 64'(m_valid), 64'd0);
    chk("t1_empty_data", 64'(m_data), 64'd0);

    // Two events in one cycle: mem record first, then reg record
    wr = 1'b1; addr = 9'h010; wr_data = 32'h55; set_reg(5'd1, 32'h7);
    tick(); clr();
    chk("t2_level", 64'(level), 64'd2);
    chk("t2_first", 64'(m_data), 64'(rec(2'b10, 9'h010, 32'h55)));
    tick();
    chk("t2_hold", 64'(m_data), 64'(rec(2'b10, 9'h010, 32'h55)));
    m_ready = 1'b1; tick();
    chk("t2_second", 64'(m_data), 64'(rec(2'b01, 9'h001, 32'h7)));
    chk("t2_level1", 64'(level), 64'd1);
    tick(); m_ready = 1'b0;
    chk("t2_drained", 64'(level), 64'd0);

    // Filtered events: capture disabled, or writes to x0
    capture_en = 1'b0; wr = 1'b1; rd = 1'b1; addr = 9'h0AA; set_reg(5'd3, 32'h1);
    tick(); clr(); capture_en = 1'b1;
    chk("t5_off_level", 64'(level), 64'd0);
    chk("t5_off_err",   64'(err_wr_rd), 64'd0);
    set_reg(5'd0, 32'hFFFF);
    tick(); clr();
    chk("t5_x0_level", 64'(level), 64'd0);
    chk("t5_x0_drop",  64'(drop_cnt), 64'd0);

    // Overflow: 18 single events into a 16-deep FIFO
    for (int i = 0; i < 18; i++) begin
      set_reg(5'(i + 1), 32'(i));
      tick();
    end
    clr();
    chk("t3_full_level", 64'(level), 64'd16);
    chk("t3_drop2",      64'(drop_cnt), 64'd2);
    chk("t3_head",       64'(m_data), 64'(rec(2'b01, 9'h001, 32'd0)));
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("t3_level15", 64'(level), 64'd15);
    // Two events with one free slot: mem record kept, reg record dropped
    wr = 1'b1; addr = 9'h033; wr_data = 32'hAA; set_reg(5'd9, 32'h99);
    tick(); clr();
    chk("t3_level16b", 64'(level), 64'd16);
    chk("t3_drop3",    64'(drop_cnt), 64'd3);
    // Full with a same-cycle pop: the push is still dropped
    m_ready = 1'b1; set_reg(5'd10, 32'h10);
    tick(); clr();
    chk("t3_popfull_level", 64'(level), 64'd15);
    chk("t3_drop4",         64'(drop_cnt), 64'd4);
    // Drain and verify order across the pointer wrap
    for (int j = 0; j < 14; j++) begin
      chk("t3_drain", 64'(m_data), 64'(rec(2'b01, 9'(j + 3), 32'(j + 2))));
      tick();
    end
    chk("t3_last", 64'(m_data), 64'(rec(2'b10, 9'h033, 32'hAA)));
    tick(); m_ready = 1'b0;
    chk("t3_empty", 64'(level), 64'd0);

    // Simultaneous wr and rd: one write record, sticky error
    wr = 1'b1; rd = 1'b1; addr = 9'h020; wr_data = 32'h11; rd_data = 32'h22;
    tick(); clr();
    chk("t4_level", 64'(level), 64'd1);
    chk("t4_data",  64'(m_data), 64'(rec(2'b10, 9'h020, 32'h11)));
    chk("t4_err",   64'(err_wr_rd), 64'd1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    // Memory read record
    rd = 1'b1; addr = 9'h021; rd_data = 32'h99;
    tick(); clr();
    chk("t4_rd_data", 64'(m_data), 64'(rec(2'b11, 9'h021, 32'h99)));
    m_ready = 1'b1; tick(); tick(); m_ready = 1'b0;
    chk("t4_err_sticky", 64'(err_wr_rd), 64'd1);
    chk("t4_empty", 64'(level), 64'd0);

    // Reset mid-drain clears everything without a clock edge
    for (int k = 0; k < 5; k++) begin
      set_reg(5'(k + 20), 32'(k + 100));
      tick();
    end
    clr();
    chk("t6_level5", 64'(level), 64'd5);
    m_ready = 1'b1; tick();
    chk("t6_level4", 64'(level), 64'd4);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", 64'(m_valid), 64'd0);
    chk("t6_async_level", 64'(level), 64'd0);
    chk("t6_async_drop",  64'(drop_cnt), 64'd0);
    chk("t6_async_err",   64'(err_wr_rd), 64'd0);
    m_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    set_reg(5'd3, 32'h1234);
    tick(); clr();
    chk("t6_resume_level", 64'(level), 64'd1);
    chk("t6_resume_data",  64'(m_data), 64'(rec(2'b01, 9'h003, 32'h1234)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
